// File: rtl/seq_lamp_ctrl.sv
// Sequential turn/hazard lamp controller with centre-outward fill animation.
// Optional brake overlay and Brake port: define SEQ_LAMP_BRAKE_EN.
module seq_lamp_ctrl #(
  parameter int LAMPS      = 3,
  parameter int TURN_TICKS = 1,
  parameter int HAZ_TICKS  = 1
) (
  input  logic             out_newclock,
  input  logic             rst_n,
  input  logic             Turn_Left,
  input  logic             Turn_Right,
  input  logic             Emergency,
`ifdef SEQ_LAMP_BRAKE_EN
  input  logic             Brake,
`endif
  output logic [LAMPS-1:0] Left_Lamp,
  output logic [LAMPS-1:0] Right_Lamp,
  output logic [1:0]       mode_o,
  output logic             cycle_done
);

  localparam int SW_RAW = $clog2(2 * LAMPS);
  localparam int SW     = (SW_RAW < 1) ? 1 : SW_RAW;
  localparam int TMAX   = (TURN_TICKS > HAZ_TICKS) ? TURN_TICKS : HAZ_TICKS;
  localparam int TW_RAW = $clog2(TMAX);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } mode_e;

  mode_e            mode_q, mode_d, req;
  logic [SW-1:0]    step_q, step_d, last_step;
  logic [TW-1:0]    tick_q, tick_d, last_tick;
  logic [LAMPS-1:0] left_q, left_d;
  logic [LAMPS-1:0] right_q, right_d;
  logic [LAMPS-1:0] pat_l, pat_r;
  logic             done_q, done_d;
  int               k;

  // Left bank lights from the top (innermost) bit downwards.
  function automatic logic [LAMPS-1:0] fill_left(input int n);
    logic [LAMPS-1:0] f;
    for (int i = 0; i < LAMPS; i++) begin
      f[i] = (i >= LAMPS - n);
    end
    return f;
  endfunction

  // Right bank lights from bit 0 (innermost) upwards.
  function automatic logic [LAMPS-1:0] fill_right(input int n);
    logic [LAMPS-1:0] f;
    for (int i = 0; i < LAMPS; i++) begin
      f[i] = (i < n);
    end
    return f;
  endfunction

  // Request priority, step/tick sequencing and next lamp pattern.
  always_comb begin
    mode_d  = mode_q;
    step_d  = step_q;
    tick_d  = tick_q;
    left_d  = left_q;
    right_d = right_q;
    done_d  = 1'b0;
    k       = 0;
    pat_l   = '0;
    pat_r   = '0;

    priority case (1'b1)
      Emergency:  req = HAZARD;
      Turn_Left:  req = LEFT;
      Turn_Right: req = RIGHT;
      default:    req = IDLE;
    endcase

    if (mode_q == HAZARD) begin
      last_tick = TW'(HAZ_TICKS - 1);
      last_step = SW'(2 * LAMPS - 1);
    end else begin
      last_tick = TW'(TURN_TICKS - 1);
      last_step = SW'(LAMPS);
    end

    if (req != mode_q) begin
      mode_d  = req;
      step_d  = '0;
      tick_d  = '0;
      left_d  = '0;
      right_d = '0;
    end else if (mode_q == IDLE) begin
      step_d  = '0;
      tick_d  = '0;
      left_d  = '0;
      right_d = '0;
`ifdef SEQ_LAMP_BRAKE_EN
      if (Brake) begin
        left_d  = '1;
        right_d = '1;
      end
`endif
    end else begin
      if (tick_q == last_tick) begin
        tick_d = '0;
        if (step_q == last_step) begin
          step_d = '0;
          done_d = 1'b1;
        end else begin
          step_d = step_q + SW'(1);
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end

      k = int'(step_d);
      if (mode_q == HAZARD && k > LAMPS) begin
        k = 2 * LAMPS - k;
      end
      pat_l = fill_left(k);
      pat_r = fill_right(k);

      unique case (mode_q)
        LEFT: begin
          left_d  = pat_l;
          right_d = '0;
`ifdef SEQ_LAMP_BRAKE_EN
          if (Brake) right_d = '1;
`endif
        end
        RIGHT: begin
          left_d  = '0;
          right_d = pat_r;
`ifdef SEQ_LAMP_BRAKE_EN
          if (Brake) left_d = '1;
`endif
        end
        default: begin
          left_d  = pat_l;
          right_d = pat_r;
        end
      endcase
    end
  end

  // State and lamp registers; reset clears everything at once.
  always_ff @(posedge out_newclock or posedge rst_n) begin
    if (rst_n) begin
      mode_q  <= IDLE;
      step_q  <= '0;
      tick_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      done_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      step_q  <= step_d;
      tick_q  <= tick_d;
      left_q  <= left_d;
      right_q <= right_d;
      done_q  <= done_d;
    end
  end

  assign Left_Lamp  = left_q;
  assign Right_Lamp = right_q;
  assign mode_o     = mode_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_seq_lamp_ctrl.sv
// Bench for seq_lamp_ctrl: per-edge model comparison plus directed
// literal checks (LAMPS=3, TURN_TICKS=1, HAZ_TICKS=2).
module tb_seq_lamp_ctrl;

  localparam int L  = 3;
  localparam int TT = 1;
  localparam int HT = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tl, tr, em;
  logic [L-1:0] left, right;
  logic [1:0]   mode;
  logic         cd;

  int checks   = 0;
  int failures = 0;

  seq_lamp_ctrl #(
    .LAMPS(L), .TURN_TICKS(TT), .HAZ_TICKS(HT)
  ) dut (
    .out_newclock(clk),
    .rst_n(rst_n),
    .Turn_Left(tl),
    .Turn_Right(tr),
    .Emergency(em),
    .Left_Lamp(left),
    .Right_Lamp(right),
    .mode_o(mode),
    .cycle_done(cd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  // Model: mode held and number of edges spent in it since entry.
  int m_mode = 0;
  int m_n    = 0;

  // Track requested mode and edges in mode.
  always @(posedge clk or posedge rst_n) begin
    int r;
    if (rst_n) begin
      m_mode = 0;
      m_n    = 0;
    end else begin
      r = em ? 3 : tl ? 1 : tr ? 2 : 0;
      if (r != m_mode) begin
        m_mode = r;
        m_n    = 0;
      end else if (m_mode != 0) begin
        m_n++;
      end
    end
  end

  // Derive expected outputs from elapsed edges and compare each cycle.
  always @(posedge clk) begin
    int t, p, s, kk;
    logic [L-1:0] ones, el, er;
    logic ecd;
    #1;
    if (!rst_n) begin
      ones = '1;
      t    = (m_mode == 3) ? HT : TT;
      p    = (m_mode == 3) ? 2 * L : L + 1;
      s    = (m_n / t) % p;
      kk   = (m_mode == 3 && s > L) ? 2 * L - s : s;
      el   = '0;
      er   = '0;
      if (m_mode == 1 || m_mode == 3) el = ~(ones >> kk);
      if (m_mode == 2 || m_mode == 3) er = ~(ones << kk);
      if (m_mode == 0) begin
        el = '0;
        er = '0;
      end
      ecd = (m_mode != 0) && (m_n > 0) &&
            (m_n % t == 0) && (s == 0);
      chk("model_mode", 32'(mode), 32'(m_mode));
      chk("model_left", 32'(left), 32'(el));
      chk("model_right", 32'(right), 32'(er));
      chk("model_cd", 32'(cd), 32'(ecd));
    end
  end

  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [L-1:0] lseq [4] = '{3'b000, 3'b100, 3'b110, 3'b111};
  logic [L-1:0] hl [12] = '{3'b000, 3'b100, 3'b100, 3'b110,
                            3'b110, 3'b111, 3'b111, 3'b110,
                            3'b110, 3'b100, 3'b100, 3'b000};
  logic [L-1:0] hr [12] = '{3'b000, 3'b001, 3'b001, 3'b011,
                            3'b011, 3'b111, 3'b111, 3'b011,
                            3'b011, 3'b001, 3'b001, 3'b000};

  initial begin
    rst_n = 1'b1;
    tl = 1'b0;
    tr = 1'b0;
    em = 1'b0;
    #1;
    chk("rst_left", 32'(left), 0);
    chk("rst_right", 32'(right), 0);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_cd", 32'(cd), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;

    @(negedge clk);
    tl = 1'b1;
    for (int i = 0; i < 9; i++) begin
      edge_n(1);
      chk("left_seq", 32'(left), 32'(lseq[i % 4]));
      chk("left_seq_right", 32'(right), 0);
      chk("left_seq_cd", 32'(cd), 32'(i > 0 && i % 4 == 0));
    end

    @(negedge clk);
    tr = 1'b1;
    edge_n(2);
    chk("both_left", 32'(left), 32'(3'b110));
    chk("both_mode", 32'(mode), 1);
    @(negedge clk);
    tl = 1'b0;
    edge_n(1);
    chk("drop_l_mode", 32'(mode), 2);
    chk("drop_l_banks", 32'({left, right}), 0);
    edge_n(2);
    chk("right_011", 32'(right), 32'(3'b011));

    @(negedge clk);
    em = 1'b1;
    edge_n(1);
    chk("haz_entry_mode", 32'(mode), 3);
    chk("haz_entry_banks", 32'({left, right}), 0);
    for (int n = 1; n <= 12; n++) begin
      edge_n(1);
      chk("haz_left", 32'(left), 32'(hl[n - 1]));
      chk("haz_right", 32'(right), 32'(hr[n - 1]));
      chk("haz_cd", 32'(cd), 32'(n == 12));
    end

    @(negedge clk);
    em = 1'b0;
    edge_n(1);
    chk("haz_exit_mode", 32'(mode), 2);
    chk("haz_exit_right", 32'(right), 0);
    edge_n(1);
    chk("right_restart", 32'(right), 32'(3'b001));

    @(negedge clk);
    em = 1'b1;
    edge_n(5);
    chk("haz_mid_left", 32'(left), 32'(3'b110));
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("async_left", 32'(left), 0);
    chk("async_right", 32'(right), 0);
    chk("async_mode", 32'(mode), 0);
    chk("async_cd", 32'(cd), 0);

    @(negedge clk);
    rst_n = 1'b0;
    em = 1'b0;
    tr = 1'b0;
    edge_n(2);
    chk("idle_mode", 32'(mode), 0);
    chk("idle_banks", 32'({left, right}), 0);

    @(posedge clk);
    #3 tl = 1'b1;
    #1 tl = 1'b0;
    edge_n(1);
    chk("pulse_mode", 32'(mode), 0);
    chk("pulse_left", 32'(left), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
